// File: rtl/race_screen_sequencer_if.sv
// race_screen_sequencer_if
// Purpose: groups the control, position and screen-enable signals exchanged
//   between the race screen sequencer and the rest of the LED racer.
// Signals:
//   start_btn    - debounced one-cycle start request
//   frame_start  - one-cycle pulse at the start of each LED frame
//   *_pos        - player positions, $clog2(MAX_POS) bits each
//   menu_en/game_en/end_en - one-hot screen enables
//   race_active  - player position counters may advance
//   pos_clear    - one-cycle pulse clearing all player positions
//   winner       - one-hot winner, bit order {yellow, blue, red, green}
// Modports: master drives the requests/positions, slave is the sequencer.
interface race_screen_sequencer_if #(
  parameter int MAX_POS = 109
);
  localparam int POS_W = $clog2(MAX_POS);

  logic             start_btn;
  logic             frame_start;
  logic [POS_W-1:0] red_pos;
  logic [POS_W-1:0] blue_pos;
  logic [POS_W-1:0] green_pos;
  logic [POS_W-1:0] yellow_pos;
  logic             menu_en;
  logic             game_en;
  logic             end_en;
  logic             race_active;
  logic             pos_clear;
  logic [3:0]       winner;

  modport master (
    output start_btn, frame_start, red_pos, blue_pos, green_pos, yellow_pos,
    input  menu_en, game_en, end_en, race_active, pos_clear, winner
  );

  modport slave (
    input  start_btn, frame_start, red_pos, blue_pos, green_pos, yellow_pos,
    output menu_en, game_en, end_en, race_active, pos_clear, winner
  );
endinterface

// File: rtl/race_screen_sequencer.sv
// race_screen_sequencer
// Purpose: top-level screen controller for the LED racer. Sequences the strip
//   through menu, race and end screens, latches the first player to reach the
//   last LED, and only changes screens on LED frame boundaries.
// Ports:
//   clk    - system clock
//   rst_n  - synchronous reset, active low
//   bus    - race_screen_sequencer_if slave modport (requests, positions,
//            screen enables, race_active, pos_clear, winner)
// Parameters:
//   MAX_POS         - number of LEDs; finish position is MAX_POS-1
//   END_HOLD_FRAMES - frames the end screen is held (>= 1)
module race_screen_sequencer #(
  parameter int MAX_POS         = 109,
  parameter int END_HOLD_FRAMES = 120
) (
  input logic                   clk,
  input logic                   rst_n,
  race_screen_sequencer_if.slave bus
);
  localparam int POS_W  = $clog2(MAX_POS);
  localparam int HOLD_W = $clog2(END_HOLD_FRAMES + 1);
  localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(MAX_POS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(END_HOLD_FRAMES - 1);

  typedef enum logic [2:0] {
    ST_MENU,
    ST_ARMED,
    ST_GAME,
    ST_FINISHED,
    ST_END
  } state_t;

  state_t            state;
  logic              menu_en;
  logic              game_en;
  logic              end_en;
  logic              race_active;
  logic              pos_clear;
  logic [3:0]        winner;
  logic [HOLD_W-1:0] hold_cnt;
  logic [3:0]        finish_hit;

  // Priority encode the finishers: green > red > blue > yellow. Only an exact
  // match counts, so out-of-range positions never register as a finish.
  always_comb begin
    finish_hit = 4'b0000;
    if (bus.green_pos == LAST_POS)       finish_hit = 4'b0001;
    else if (bus.red_pos == LAST_POS)    finish_hit = 4'b0010;
    else if (bus.blue_pos == LAST_POS)   finish_hit = 4'b0100;
    else if (bus.yellow_pos == LAST_POS) finish_hit = 4'b1000;
  end

  // Screen FSM with registered outputs. Every transition into or out of a
  // screen is qualified by frame_start so a frame never spans two screens.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_MENU;
      menu_en     <= 1'b1;
      game_en     <= 1'b0;
      end_en      <= 1'b0;
      race_active <= 1'b0;
      pos_clear   <= 1'b0;
      winner      <= 4'b0000;
      hold_cnt    <= '0;
    end else begin
      pos_clear <= 1'b0;
      case (state)
        ST_MENU: begin
          if (bus.start_btn) begin
            if (bus.frame_start) begin
              state       <= ST_GAME;
              menu_en     <= 1'b0;
              game_en     <= 1'b1;
              race_active <= 1'b1;
              pos_clear   <= 1'b1;
            end else begin
              state <= ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (bus.frame_start) begin
            state       <= ST_GAME;
            menu_en     <= 1'b0;
            game_en     <= 1'b1;
            race_active <= 1'b1;
            pos_clear   <= 1'b1;
          end
        end
        ST_GAME: begin
          if (finish_hit != 4'b0000) begin
            winner      <= finish_hit;
            race_active <= 1'b0;
            if (bus.frame_start) begin
              // Finish on a frame boundary skips FINISHED entirely.
              state    <= ST_END;
              game_en  <= 1'b0;
              end_en   <= 1'b1;
              hold_cnt <= '0;
            end else begin
              state <= ST_FINISHED;
            end
          end
        end
        ST_FINISHED: begin
          if (bus.frame_start) begin
            state    <= ST_END;
            game_en  <= 1'b0;
            end_en   <= 1'b1;
            hold_cnt <= '0;
          end
        end
        ST_END: begin
          if (bus.frame_start) begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= ST_MENU;
              end_en   <= 1'b0;
              menu_en  <= 1'b1;
              winner   <= 4'b0000;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end
        default: begin
          state       <= ST_MENU;
          menu_en     <= 1'b1;
          game_en     <= 1'b0;
          end_en      <= 1'b0;
          race_active <= 1'b0;
          winner      <= 4'b0000;
          hold_cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.menu_en     = menu_en;
  assign bus.game_en     = game_en;
  assign bus.end_en      = end_en;
  assign bus.race_active = race_active;
  assign bus.pos_clear   = pos_clear;
  assign bus.winner      = winner;
endmodule

// File: tb/tb_race_screen_sequencer.sv
// tb_race_screen_sequencer
// Purpose: self-checking bench for race_screen_sequencer. Directed scenarios
//   followed by randomized traffic, all compared against a behavioural model
//   of the screen rules kept in this file.
module tb_race_screen_sequencer;
  localparam int MAX_POS = 109;
  localparam int HOLD    = 3;
  localparam int POS_W   = $clog2(MAX_POS);

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  race_screen_sequencer_if #(.MAX_POS(MAX_POS)) bus ();

  race_screen_sequencer #(
    .MAX_POS(MAX_POS),
    .END_HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: screen (0 menu, 1 race, 2 end), plus flags for a pending
  // start, a race already decided, and the number of end-screen frames seen.
  int         screen = 0;
  bit         start_pending = 1'b0;
  bit         decided = 1'b0;
  bit         clear_pulse = 1'b0;
  logic [3:0] champ = 4'b0000;
  int         end_frames = 0;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Apply the screen rules to the inputs the DUT just sampled.
  task automatic modelStep();
    logic [POS_W-1:0] order [4];
    int first;
    order = '{bus.green_pos, bus.red_pos, bus.blue_pos, bus.yellow_pos};
    if (!rst_n) begin
      screen = 0; start_pending = 0; decided = 0; champ = 0;
      end_frames = 0; clear_pulse = 0;
      return;
    end
    clear_pulse = 0;
    if (screen == 0) begin
      if (bus.frame_start && (bus.start_btn || start_pending)) begin
        screen = 1; clear_pulse = 1; start_pending = 0; decided = 0;
      end else if (bus.start_btn) begin
        start_pending = 1;
      end
    end else if (screen == 1) begin
      if (!decided) begin
        first = -1;
        for (int i = 0; i < 4; i++)
          if (first < 0 && int'(order[i]) == MAX_POS - 1) first = i;
        if (first >= 0) begin
          champ = 4'(1 << first);
          decided = 1;
          if (bus.frame_start) begin screen = 2; end_frames = 0; end
        end
      end else if (bus.frame_start) begin
        screen = 2; end_frames = 0;
      end
    end else begin
      if (bus.frame_start) begin
        end_frames++;
        if (end_frames == HOLD) begin screen = 0; champ = 0; end
      end
    end
  endtask

  task automatic compareModel();
    checkOutput("menu_en", bus.menu_en, screen == 0);
    checkOutput("game_en", bus.game_en, screen == 1);
    checkOutput("end_en", bus.end_en, screen == 2);
    checkOutput("race_active", bus.race_active, screen == 1 && !decided);
    checkOutput("pos_clear", bus.pos_clear, clear_pulse);
    checkOutput("winner", bus.winner, champ);
  endtask

  task automatic applyStimulus(input logic start, input logic fs);
    bus.start_btn   = start;
    bus.frame_start = fs;
    @(posedge clk);
    #1;
    modelStep();
    compareModel();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic clearPos();
    bus.green_pos = '0; bus.red_pos = '0; bus.blue_pos = '0; bus.yellow_pos = '0;
  endtask

  function automatic logic [POS_W-1:0] randPos();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return POS_W'(MAX_POS - 1);
    if (r == 1) return POS_W'($urandom_range(MAX_POS, (1 << POS_W) - 1));
    return POS_W'($urandom_range(0, MAX_POS - 2));
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.start_btn = 1'b0;
    bus.frame_start = 1'b0;
    clearPos();

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      bus.green_pos = randPos(); bus.red_pos = randPos();
      bus.blue_pos = randPos(); bus.yellow_pos = randPos();
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    checkOutput("rst_menu", bus.menu_en, 1);
    checkOutput("rst_winner", bus.winner, 0);
    checkOutput("rst_active", bus.race_active, 0);
    clearPos();
    rst_n = 1'b1;
    idle(20);
    checkOutput("idle_menu", bus.menu_en, 1);

    // Start then a frame ten cycles later.
    applyStimulus(1'b1, 1'b0);
    idle(9);
    checkOutput("armed_menu", bus.menu_en, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("go_game", bus.game_en, 1);
    checkOutput("go_active", bus.race_active, 1);
    checkOutput("go_clear", bus.pos_clear, 1);
    idle(1);
    checkOutput("clear_once", bus.pos_clear, 0);

    // Green and yellow finish together; green wins, red later changes nothing.
    idle(3);
    bus.green_pos = 7'd108; bus.yellow_pos = 7'd108;
    idle(1);
    checkOutput("prio_winner", bus.winner, 4'b0001);
    checkOutput("prio_frozen", bus.race_active, 0);
    clearPos();
    bus.red_pos = 7'd108;
    idle(2);
    checkOutput("late_red", bus.winner, 4'b0001);
    clearPos();
    idle(9);
    applyStimulus(1'b0, 1'b1);
    checkOutput("end_entry", bus.end_en, 1);
    idle(9);
    applyStimulus(1'b0, 1'b1);
    idle(4);
    applyStimulus(1'b1, 1'b0);
    idle(4);
    applyStimulus(1'b0, 1'b1);
    checkOutput("end_hold", bus.end_en, 1);
    idle(9);
    applyStimulus(1'b0, 1'b1);
    checkOutput("end_exit", bus.menu_en, 1);
    checkOutput("end_clear", bus.winner, 0);

    // Start and frame together, then blue finishes on a frame boundary.
    applyStimulus(1'b1, 1'b1);
    checkOutput("fast_game", bus.game_en, 1);
    idle(2);
    bus.blue_pos = 7'd108;
    applyStimulus(1'b0, 1'b1);
    checkOutput("direct_end", bus.end_en, 1);
    checkOutput("direct_winner", bus.winner, 4'b0100);
    clearPos();
    for (int i = 0; i < HOLD; i++) begin
      idle(2);
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("back_menu", bus.menu_en, 1);

    // Reset while the end screen shows red as winner.
    applyStimulus(1'b1, 1'b1);
    bus.red_pos = 7'd108;
    idle(1);
    clearPos();
    applyStimulus(1'b0, 1'b1);
    checkOutput("red_end", bus.winner, 4'b0010);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    checkOutput("mid_rst_menu", bus.menu_en, 1);
    checkOutput("mid_rst_winner", bus.winner, 0);
    applyStimulus(1'b1, 1'b0);
    idle(9);
    applyStimulus(1'b0, 1'b1);
    checkOutput("restart_game", bus.game_en, 1);
    checkOutput("restart_clear", bus.pos_clear, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      bus.green_pos = randPos(); bus.red_pos = randPos();
      bus.blue_pos = randPos(); bus.yellow_pos = randPos();
      applyStimulus(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
